dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
Shares the single data port (port 1) of the dual-port async instruction/data RAM between two masters: m0 = CPU load/store path and m1 = a secondary master (UART loader/DMA).
- m0 has fixed priority; a wait counter guarantees that m1 cannot starve.
- m1 may lock the port for short bursts.
- Sits between the core/loader and the RAM port 1 pins. Drives the CPU stall.

Parameters:
DWIDTH, 32, data width.
AWIDTH, 12, word-address width of the RAM.
MAX_WAIT, 4, consecutive denied m1 cycles before m1 is forced a grant (1..255).
LOCK_MAX, 16, maximum consecutive locked m1 grants (1..255).

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
m0_req  input  1  CPU requests an access this cycle
m0_we  input  1  CPU write (1) / read (0)
m0_addr  input  AWIDTH  CPU word address
m0_wdata  input  DWIDTH  CPU write data
m0_be  input  4  CPU byte enables
m0_gnt  output  1  CPU access performed this cycle
m0_stall  output  1  m0_req & ~m0_gnt
m0_rdata  output  DWIDTH  read data to CPU
m1_req  input  1  m1 request
m1_lock  input  1  m1 requests to keep ownership after this grant
m1_we  input  1  m1 write/read
m1_addr  input  AWIDTH  m1 word address
m1_wdata  input  DWIDTH  m1 write data
m1_be  input  4  m1 byte enables
m1_gnt  output  1  m1 access performed this cycle
m1_rdata  output  DWIDTH  read data to m1
mem_addr  output  AWIDTH  to RAM addr1
mem_wdata  output  DWIDTH  to RAM d1
mem_be  output  4  to RAM wbe1
mem_wen  output  1  to RAM wen1
mem_rdata  input  DWIDTH  from RAM q1

Behaviour:
- Transfer rule: a master holds req and its command stable until it sees gnt. The access completes in the cycle gnt=1. Read data returns combinationally in the same cycle because the RAM read is async; the write commits at the next clk edge.
- m0_gnt and m1_gnt are never high together. Each gnt is combinational from req plus the registered state.
- State register st: ARB or LOCK.
- ARB state:
  - if wait_cnt==MAX_WAIT and m1_req: grant m1;
  - else if m0_req: grant m0;
  - else if m1_req: grant m1.
  - If m1 is granted with m1_lock=1 and LOCK_MAX>1: next st=LOCK, lock_cnt<=1.
- LOCK state:
  - m1_gnt=m1_req and m0_gnt=0.
  - Each m1 grant increments lock_cnt.
  - Exit to ARB when m1_lock=0 at a grant, m1_req=0, or lock_cnt reaches LOCK_MAX after a grant. The CPU regains the port the following cycle.
- wait_cnt (8 bit):
  - increments, saturating at MAX_WAIT, each cycle m1_req & ~m1_gnt;
  - clears on any m1_gnt or when m1_req=0.
- Mem mux:
  - mem_* = granted master's command;
  - mem_wen = gnt & we of the granted master;
  - with no grant: mem_wen=0, mem_be=0, mem_addr=0, mem_wdata=0.
- rdata: m0_rdata = m1_rdata = mem_rdata, unqualified. A master samples it only when its gnt=1.
- Simultaneous m0/m1 requests with wait_cnt<MAX_WAIT: m0 wins and wait_cnt increments.
- Reset values (async, n_rst=0): st=ARB, wait_cnt=0, lock_cnt=0. All gnt=0, m0_stall=0, mem_wen=0, mem_be=0.
- Reset asserted mid-lock: ownership is dropped immediately and no write is issued while n_rst=0. Outputs are gated, and mem_wen=0 during reset.

Optional Feature:
DMEM_ARB_STATS_EN:
- Defined: adds output conflict_cnt[15:0] and output m1_grant_cnt[15:0].
  - conflict_cnt increments each cycle both req are high.
  - m1_grant_cnt increments on each m1_gnt.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dmem_arb_pkg:
  - state encoding ST_ARB=1'b0, ST_LOCK=1'b1;
  - command struct fields (we, addr, wdata, be) as width constants;
  - default MAX_WAIT/LOCK_MAX.
- One natural sub-module: dmem_arb_sat_cnt, a parameterised saturating counter with clear and increment. It is reused for wait_cnt, lock_cnt and the stats counters.

Test Plan:
- Solo m0: m0 write addr 12'h010, wdata 32'hDEADBEEF, be 4'hF -> m0_gnt=1 the same cycle, mem_wen=1, m0_stall=0. Then a read of 12'h010 returns 32'hDEADBEEF in its gnt cycle.
- Starvation: m0_req and m1_req held high continuously, MAX_WAIT=4 -> m0 is granted for 4 cycles, m1 on the 5th, then m0 again. The pattern repeats with period 5 and m0_stall=1 only in the m1 cycles.
- Lock burst: m1_lock=1 with 20 requests at addr 12'h100.., LOCK_MAX=16 -> 16 consecutive m1 grants with m0 stalled. Then ≥1 m0 grant, after which m1 re-arbitrates.
- Lock release: m1_lock drops at the 3rd grant -> st returns to ARB and a pending m0 is granted the next cycle.
- Async reset mid-lock: n_rst=0 at lock_cnt=7 -> gnts and mem_wen are 0 immediately. After release, st=ARB, counters are 0, and m0 is granted first.
- Stats (DMEM_ARB_STATS_EN): 10 cycles of dual requests -> conflict_cnt=10 and m1_grant_cnt=2.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and default sizing for the data-port arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_st_t;

  // Widths of the RAM port 1 command fields.
  localparam int CMD_WE_W    = 1;
  localparam int CMD_ADDR_W  = 12;
  localparam int CMD_WDATA_W = 32;
  localparam int CMD_BE_W    = 4;

  localparam int DEF_MAX_WAIT = 4;
  localparam int DEF_LOCK_MAX = 16;
  localparam int CNT_W        = 8;
  localparam int STAT_W       = 16;

endpackage

// File: rtl/dmem_arb_sat_cnt.sv
// Saturating up-counter; clear wins over increment, and clear+inc restarts at 1.
module dmem_arb_sat_cnt #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] LIM = W'(MAX);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                 cnt <= '0;
    else if (clr)               cnt <= inc ? ONE : '0;
    else if (inc && cnt != LIM) cnt <= cnt + ONE;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates RAM port 1 between the CPU (m0, priority) and a loader/DMA (m1, lockable).
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 12,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [AWIDTH-1:0]   m0_addr,
  input  logic [DWIDTH-1:0]   m0_wdata,
  input  logic [CMD_BE_W-1:0] m0_be,
  output logic                m0_gnt,
  output logic                m0_stall,
  output logic [DWIDTH-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_lock,
  input  logic                m1_we,
  input  logic [AWIDTH-1:0]   m1_addr,
  input  logic [DWIDTH-1:0]   m1_wdata,
  input  logic [CMD_BE_W-1:0] m1_be,
  output logic                m1_gnt,
  output logic [DWIDTH-1:0]   m1_rdata,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_wdata,
  output logic [CMD_BE_W-1:0] mem_be,
  output logic                mem_wen,
  input  logic [DWIDTH-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   conflict_cnt,
  output logic [STAT_W-1:0]   m1_grant_cnt
`endif
);

  localparam logic [CNT_W-1:0] WAIT_LIM  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  arb_st_t          st, st_nxt;
  logic             g0, g1;
  logic             force_m1;
  logic [CNT_W-1:0] wait_cnt, lock_cnt;

  assign force_m1 = m1_req && (wait_cnt == WAIT_LIM);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) st <= ST_ARB;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_ARB:  if (g1 && m1_lock && (LOCK_MAX > 1)) st_nxt = ST_LOCK;
      ST_LOCK: if (!m1_req || (g1 && (!m1_lock || lock_cnt == LOCK_LAST))) st_nxt = ST_ARB;
      default: st_nxt = ST_ARB;
    endcase
  end

  // Internal grants are ungated; the port-level versions are forced low while in reset.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    case (st)
      ST_ARB: begin
        if (force_m1)    g1 = 1'b1;
        else if (m0_req) g0 = 1'b1;
        else if (m1_req) g1 = 1'b1;
      end
      ST_LOCK: g1 = m1_req;
      default: ;
    endcase
  end

  assign m0_gnt   = g0 && n_rst;
  assign m1_gnt   = g1 && n_rst;
  assign m0_stall = m0_req && !m0_gnt && n_rst;
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_wen   = 1'b0;
    if (m0_gnt) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_be    = m0_be;
      mem_wen   = m0_we;
    end else if (m1_gnt) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_be    = m1_be;
      mem_wen   = m1_we;
    end
  end

  dmem_arb_sat_cnt #(.W(CNT_W), .MAX(MAX_WAIT)) u_wait_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (g1 || !m1_req),
    .inc   (m1_req && !g1),
    .cnt   (wait_cnt)
  );

  // Held clear in ARB; the grant that enters LOCK loads 1.
  dmem_arb_sat_cnt #(.W(CNT_W), .MAX(LOCK_MAX)) u_lock_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (st == ST_ARB),
    .inc   (g1 && (st == ST_LOCK || st_nxt == ST_LOCK)),
    .cnt   (lock_cnt)
  );

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_sat_cnt #(.W(STAT_W), .MAX(65535)) u_conflict_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (1'b0),
    .inc   (m0_req && m1_req),
    .cnt   (conflict_cnt)
  );

  dmem_arb_sat_cnt #(.W(STAT_W), .MAX(65535)) u_m1_grant_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (1'b0),
    .inc   (g1),
    .cnt   (m1_grant_cnt)
  );
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a behavioural async-read RAM.
module tb_dmem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          m0_req, m0_we, m0_gnt, m0_stall;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [3:0]    m0_be;
  logic          m1_req, m1_lock, m1_we, m1_gnt;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [3:0]    m1_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic          mem_wen;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   conflict_cnt, m1_grant_cnt;
`endif

  dmem_port_arbiter dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_be     (m0_be),
    .m0_gnt    (m0_gnt),
    .m0_stall  (m0_stall),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_be     (m1_be),
    .m1_gnt    (m1_gnt),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .m1_grant_cnt (m1_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  int            wr_cnt = 0;

  always @(posedge clk) begin
    if (mem_wen) begin
      if (mem_be[0]) ram[mem_addr][7:0]   <= mem_wdata[7:0];
      if (mem_be[1]) ram[mem_addr][15:8]  <= mem_wdata[15:8];
      if (mem_be[2]) ram[mem_addr][23:16] <= mem_wdata[23:16];
      if (mem_be[3]) ram[mem_addr][31:24] <= mem_wdata[31:24];
      wr_cnt <= wr_cnt + 1;
    end
  end

  assign mem_rdata = ram[mem_addr];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_be = 4'h0;
    m1_req = 1'b0; m1_lock = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = 4'h0;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  int ng;
  int wc;
  logic exp1;

  initial begin
    n_rst = 1'b0;
    idle();
    m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'hF;
    m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hF;
    #3;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_stall", m0_stall, 0);
    chk("rst_wen", mem_wen, 0);
    chk("rst_be", mem_be, 0);
`ifdef DMEM_ARB_STATS_EN
    chk("rst_conflict", conflict_cnt, 0);
    chk("rst_m1grants", m1_grant_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle();

    // Solo CPU write then read-back
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h010; m0_wdata = 32'hDEADBEEF; m0_be = 4'hF;
    @(negedge clk);
    chk("wr_m0_gnt", m0_gnt, 1);
    chk("wr_wen", mem_wen, 1);
    chk("wr_stall", m0_stall, 0);
    chk("wr_addr", mem_addr, 12'h010);
    chk("wr_m1_gnt", m1_gnt, 0);
    next_cyc();
    m0_we = 1'b0; m0_wdata = '0;
    @(negedge clk);
    chk("rd_m0_gnt", m0_gnt, 1);
    chk("rd_wen", mem_wen, 0);
    chk("rd_data", m0_rdata, 32'hDEADBEEF);
    next_cyc();
    idle();
    @(negedge clk);
    chk("idle_addr", mem_addr, 0);
    chk("idle_be", mem_be, 0);
    chk("idle_wen", mem_wen, 0);
    chk("idle_stall", m0_stall, 0);
    next_cyc();

    // Continuous contention: m0 x4, m1 x1, repeating
    m0_req = 1'b1; m0_addr = 12'h010; m0_be = 4'hF;
    m1_req = 1'b1; m1_addr = 12'h020; m1_be = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("starve_m1_gnt[%0d]", i), m1_gnt, (i % 5) == 4);
      chk($sformatf("starve_m0_gnt[%0d]", i), m0_gnt, (i % 5) != 4);
      chk($sformatf("starve_stall[%0d]", i), m0_stall, (i % 5) == 4);
      next_cyc();
    end
    idle();
`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    chk("stat_conflict", conflict_cnt, 10);
    chk("stat_m1grants", m1_grant_cnt, 2);
`endif
    next_cyc();

    // Locked burst capped at 16 grants; CPU then gets one slot
    ng = 0;
    for (int k = 0; k < 18; k++) begin
      m0_req = (k != 0) && (k != 17);
      m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b1; m1_be = 4'hF;
      m1_addr = 12'h100 + AW'(ng); m1_wdata = DW'(ng);
      @(negedge clk);
      exp1 = (k < 16) || (k == 17);
      chk($sformatf("lock_m1_gnt[%0d]", k), m1_gnt, exp1);
      chk($sformatf("lock_m0_gnt[%0d]", k), m0_gnt, k == 16);
      chk($sformatf("lock_stall[%0d]", k), m0_stall, (k >= 1) && (k <= 15));
      if (exp1) begin
        chk($sformatf("lock_addr[%0d]", k), mem_addr, 12'h100 + AW'(ng));
        ng++;
      end
      next_cyc();
    end
    idle();
    chk("lock_ram_10f", ram[12'h10F], 32'd15);
    chk("lock_ram_110", ram[12'h110], 32'd16);
    next_cyc();

    // Lock released at the third grant hands the port back to m0 next cycle
    for (int k = 0; k < 4; k++) begin
      m0_req = (k != 0);
      m1_req = (k < 3); m1_lock = (k < 2); m1_we = 1'b0; m1_addr = 12'h180;
      @(negedge clk);
      chk($sformatf("rel_m1_gnt[%0d]", k), m1_gnt, k < 3);
      chk($sformatf("rel_m0_gnt[%0d]", k), m0_gnt, k == 3);
      next_cyc();
    end
    idle();
    next_cyc();

    // Reset asserted with lock_cnt at 7
    for (int k = 0; k < 7; k++) begin
      m0_req = (k != 0);
      m1_req = 1'b1; m1_lock = 1'b1; m1_we = 1'b1; m1_be = 4'hF;
      m1_addr = 12'h200 + AW'(k); m1_wdata = 32'hA5A50000 + DW'(k);
      @(negedge clk);
      chk($sformatf("rlock_m1_gnt[%0d]", k), m1_gnt, 1);
      next_cyc();
    end
    m1_addr = 12'h207; m1_wdata = 32'hA5A50007;
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_m1_gnt", m1_gnt, 0);
    chk("arst_m0_gnt", m0_gnt, 0);
    chk("arst_wen", mem_wen, 0);
    chk("arst_stall", m0_stall, 0);
    wc = wr_cnt;
    next_cyc();
    chk("arst_no_write", wr_cnt, wc);
`ifdef DMEM_ARB_STATS_EN
    chk("arst_conflict", conflict_cnt, 0);
    chk("arst_m1grants", m1_grant_cnt, 0);
`endif
    n_rst = 1'b1;
    m1_lock = 1'b0; m1_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("post_m0_gnt[%0d]", i), m0_gnt, i < 4);
      chk($sformatf("post_m1_gnt[%0d]", i), m1_gnt, i == 4);
      next_cyc();
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
